// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 8-bit ALU. It accepts one instruction at a time,
// issues it to the registered ALU, and writes the result back one cycle later.
module alu_issue_ctrl #(
  parameter logic [7:0] RF_RESET_VAL = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic        alu_en,
  output logic [3:0]  alu_opcode,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [7:0]  alu_shamt,
  input  logic [7:0]  alu_result,
  input  logic        alu_zero,
  input  logic        alu_carry,
  output logic        done,
  output logic        done_err,
  output logic [1:0]  done_rd,
  output logic [7:0]  done_data,
  output logic        zero_flag,
  output logic        carry_flag,
  input  logic [1:0]  dbg_addr,
  output logic [7:0]  dbg_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, WB, WB_ERR} state_t;

  state_t          state_q, state_d;
  logic [3:0][7:0] rf_q;
  logic [1:0]      rd_q;
  logic            accept;
  logic            legal;

  assign accept   = instr_valid && instr_ready;
  assign legal    = (instr[15:12] <= 4'd9);
  assign dbg_data = rf_q[dbg_addr];

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    alu_en      = 1'b0;
    done        = 1'b0;
    done_err    = 1'b0;
    done_rd     = 2'd0;
    done_data   = 8'h00;
    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = legal ? ISSUE : WB_ERR;
      end
      ISSUE: begin
        alu_en  = 1'b1;
        state_d = WB;
      end
      WB: begin
        done      = 1'b1;
        done_rd   = rd_q;
        done_data = alu_result;
        state_d   = IDLE;
      end
      WB_ERR: begin
        done     = 1'b1;
        done_err = 1'b1;
        done_rd  = rd_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Operands are captured at accept: nothing writes the register file between
  // accept and ISSUE, so this equals reading it during ISSUE, and the registers
  // naturally hold their values outside ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q       <= 2'd0;
      alu_opcode <= 4'd0;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      alu_shamt  <= 8'h00;
    end else if (accept) begin
      rd_q <= instr[11:10];
      if (legal) begin
        alu_opcode <= instr[15:12];
        alu_a      <= rf_q[instr[11:10]];
        alu_b      <= rf_q[instr[9:8]];
        alu_shamt  <= instr[7:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_q       <= {4{RF_RESET_VAL}};
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else if (state_q == WB) begin
      rf_q[rd_q] <= alu_result;
      zero_flag  <= alu_zero;
      carry_flag <= alu_carry;
    end
  end

endmodule
